data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 8, is the number of 32-bit data words stored; the legal range is powers of two from 2 to 256.
REQ-002 Parameter WAIT_CYCLES, default 2, is the number of wait states between request acceptance and memory commit; the legal range is 0..15.
REQ-003 Port clk  input  1  is the single clock; every register updates on the rising edge.
REQ-004 Port reset  input  1  is the reset; it SHALL be asynchronous and active-low.
REQ-005 Port req_valid  input  1  means the core presents a load or store request.
REQ-006 Port req_ready  output  1  means the responder can accept a request this cycle.
REQ-007 Port req_we  input  1  selects the operation: 1 = store (sw), 0 = load (lw).
REQ-008 Port req_addr  input  32  is the word index (ALU result), not a byte address.
REQ-009 Port req_wdata  input  32  is the store data.
REQ-010 Port rsp_valid  output  1  means a response is presented.
REQ-011 Port rsp_ready  input  1  means the core accepts the response.
REQ-012 Port rsp_rdata  output  32  is the load data; it SHALL be 0 for stores and for errored requests.
REQ-013 Port rsp_err  output  1  flags an out-of-range address; it is meaningful only with DMEM_RANGE_CHECK_EN defined.
REQ-014 Port busy  output  1  SHALL be high in every state except IDLE.
REQ-015 Port txn_count  output  16  counts completed response handshakes.

Function
REQ-016 The state machine SHALL have three states: IDLE, WAIT and RESP; req_ready SHALL be high only in IDLE.
REQ-017 IDLE: on req_valid=1 the block SHALL accept the request, capturing req_we, req_addr and req_wdata.
- Next state is WAIT when WAIT_CYCLES>0.
- Next state is RESP when WAIT_CYCLES=0.
REQ-018 WAIT: a 4-bit down-counter, loaded with WAIT_CYCLES-1 at acceptance, SHALL decrement every cycle; the state moves to RESP on the edge where the counter equals 0.
REQ-019 Commit SHALL occur on the edge that enters RESP:
- Store: the captured word is written to memory.
- Load: rsp_rdata is registered from memory.
REQ-020 rsp_valid SHALL rise exactly WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-021 RESP: rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_ready=1; on that handshake edge the state returns to IDLE and rsp_valid falls.
REQ-022 No request is accepted on the response-handshake edge; the minimum request-to-request spacing is WAIT_CYCLES+2 cycles when rsp_ready is held high.
REQ-023 A load issued after a completed store to the same address SHALL return the stored data.
REQ-024 Inputs req_we, req_addr and req_wdata changing after acceptance SHALL NOT affect the in-flight transaction.
REQ-025 txn_count SHALL increment by 1 on every response handshake and saturate at 16'hFFFF with no wrap-around.

Reset
REQ-026 reset=0 SHALL immediately force the following, regardless of the clock:
- state = IDLE
- wait counter = 0
- rsp_valid = 0, rsp_rdata = 0, rsp_err = 0
- txn_count = 0
- busy = 0
REQ-027 Memory contents SHALL NOT be cleared by reset.
REQ-028 A reset asserted during WAIT SHALL abort the transaction: an uncommitted store is not written.
REQ-029 req_ready SHALL be 0 while reset=0 and rise in the first cycle after reset release.

Configuration
REQ-030 With DMEM_RANGE_CHECK_EN defined, a request with req_addr >= DEPTH SHALL:
- perform no memory write;
- return rsp_rdata = 0 and rsp_err = 1;
- follow the same timing as a legal request and count in txn_count.
REQ-031 Without DMEM_RANGE_CHECK_EN:
- the address SHALL be taken modulo DEPTH (low log2(DEPTH) bits);
- rsp_err SHALL be tied to 0.

Verification
REQ-032 Defaults, store addr=1 data=32'h1C, then load addr=1 with rsp_ready=1 -> load rsp_valid rises 3 cycles after acceptance, rsp_rdata=32'h1C, txn_count=2.
REQ-033 WAIT_CYCLES=0, load addr=2 after storing 32'h7 -> rsp_valid 1 cycle after acceptance, rsp_rdata=32'h7.
REQ-034 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready=0, req_valid ignored; release -> IDLE next cycle.
REQ-035 With DMEM_RANGE_CHECK_EN, store addr=9 data=32'hFF, then load addr=1 -> rsp_err=1 on the store, word 1 unchanged; without the macro the store writes word 1 (rdata=32'hFF).
REQ-036 Store addr=3 data=32'hAA, reset pulsed during WAIT -> outputs zeroed asynchronously, later load addr=3 returns the prior contents, not 32'hAA.
REQ-037 Force txn_count to 16'hFFFE, complete 3 transactions -> txn_count reads 16'hFFFF.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed 32-bit data memory behind a valid/ready
// request/response handshake, with a fixed number of wait states before commit.
// Optional build macro: DMEM_RANGE_CHECK_EN -- requests with req_addr >= DEPTH
// are flagged with rsp_err and do not touch memory; without it the address
// wraps modulo DEPTH and rsp_err is tied low.
//
// state | meaning
// IDLE  | ready to accept a request
// WAIT  | request captured, wait counter running down
// RESP  | response presented, holding until rsp_ready

module data_mem_responder #(
   parameter int DEPTH       = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy,
   output logic [15:0] txn_count
);

   localparam int         AW        = $clog2(DEPTH);
   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    wcnt_q, wcnt_d;
   logic          rdy_q;
   logic          cap_we_q;
   logic [31:0]   cap_addr_q;
   logic [31:0]   cap_wdata_q;
   logic [31:0]   mem [DEPTH];
   logic          accept;
   logic          commit;
   logic          handshake;
   logic          cur_we;
   logic [31:0]   cur_addr;
   logic [31:0]   cur_wdata;
   logic [AW-1:0] idx;
   logic          addr_ok;

   // With zero wait states the commit happens on the acceptance edge itself,
   // so the live request fields are used while still in IDLE.
   assign cur_we    = (state_q == IDLE) ? req_we    : cap_we_q;
   assign cur_addr  = (state_q == IDLE) ? req_addr  : cap_addr_q;
   assign cur_wdata = (state_q == IDLE) ? req_wdata : cap_wdata_q;
   assign idx       = cur_addr[AW-1:0];

`ifdef DMEM_RANGE_CHECK_EN
   assign addr_ok = (cur_addr < 32'(DEPTH));
`else
   assign addr_ok = 1'b1;
   logic unused_addr_hi;
   assign unused_addr_hi = &{1'b0, cur_addr[31:AW]};
`endif

   // rdy_q keeps req_ready low through reset and for the rest of that cycle.
   assign req_ready = (state_q == IDLE) && rdy_q;
   assign busy      = (state_q != IDLE);

   // Next-state logic and per-cycle strobes.
   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      accept    = 1'b0;
      commit    = 1'b0;
      handshake = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid && rdy_q) begin
               accept = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  state_d = RESP;
                  commit  = 1'b1;
               end else begin
                  state_d = WAIT;
                  wcnt_d  = WAIT_LOAD;
               end
            end
         end
         WAIT: begin
            if (wcnt_q == 4'd0) begin
               state_d = RESP;
               commit  = 1'b1;
            end else begin
               wcnt_d = wcnt_q - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               handshake = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register, wait counter and post-reset ready enable.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         wcnt_q  <= 4'd0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         rdy_q   <= 1'b1;
      end
   end

   // Capture the request so later input changes cannot disturb it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cap_we_q    <= 1'b0;
         cap_addr_q  <= 32'd0;
         cap_wdata_q <= 32'd0;
      end else if (accept) begin
         cap_we_q    <= req_we;
         cap_addr_q  <= req_addr;
         cap_wdata_q <= req_wdata;
      end
   end

   // Storage array; intentionally not reset so contents survive a reset.
   always_ff @(posedge clk) begin
      if (commit && cur_we && addr_ok) begin
         mem[idx] <= cur_wdata;
      end
   end

   // Response data/valid and saturating handshake counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'd0;
         txn_count <= 16'd0;
      end else if (commit) begin
         rsp_valid <= 1'b1;
         rsp_rdata <= (!cur_we && addr_ok) ? mem[idx] : 32'd0;
      end else if (handshake) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'd0;
         if (txn_count != 16'hFFFF) begin
            txn_count <= txn_count + 16'd1;
         end
      end
   end

`ifdef DMEM_RANGE_CHECK_EN
   // Error flag follows the same commit/handshake timing as the data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp_err <= 1'b0;
      end else if (commit) begin
         rsp_err <= ~addr_ok;
      end else if (handshake) begin
         rsp_err <= 1'b0;
      end
   end
`else
   assign rsp_err = 1'b0;
`endif

endmodule
